// File: rtl/hififo_test_engine.sv
// hififo_test_engine
//   Per-channel test endpoint for hififo_pcie FIFO pairs. Each channel pairs
//   one FPC (from-PC) FIFO with one TPC (to-PC) FIFO. Each channel runs in its
//   own mode: idle, loopback, counter source or counter checker.
//
// Ports
//   clock       single clock for all channels
//   reset       asynchronous, active-high; clears all state
//   mode        2 bits per channel: 0 idle, 1 loopback, 2 source, 3 checker
//   fifo_reset  per-channel FIFO reset from hififo (active-high)
//   err_clear   synchronous pulse, zeroes every error counter
//   fpc_ready   FPC FIFO holds a word (first-word fall-through)
//   fpc_data    FPC word per channel, channel c at [c*WIDTH +: WIDTH]
//   fpc_read    combinational pop strobe for the word presented this cycle
//   tpc_ready   TPC FIFO has room for at least 2 more words
//   tpc_write   registered push strobe
//   tpc_data    registered TPC word per channel
//   word_count  32 bits per channel; words consumed or produced, wraps
//   err_count   ERRW bits per channel; checker mismatches, saturating
//   led         low nibble of the last word popped on channel 0
module hififo_test_engine #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 64,
  parameter int ERRW     = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [CHANNELS-1:0]       fifo_reset,
  input  logic                      err_clear,
  input  logic [CHANNELS-1:0]       fpc_ready,
  input  logic [WIDTH*CHANNELS-1:0] fpc_data,
  output logic [CHANNELS-1:0]       fpc_read,
  input  logic [CHANNELS-1:0]       tpc_ready,
  output logic [CHANNELS-1:0]       tpc_write,
  output logic [WIDTH*CHANNELS-1:0] tpc_data,
  output logic [32*CHANNELS-1:0]    word_count,
  output logic [ERRW*CHANNELS-1:0]  err_count,
  output logic [3:0]                led
);

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_LOOP = 2'd1,
    MODE_SRC  = 2'd2,
    MODE_CHK  = 2'd3
  } mode_e;

  logic [3:0] r_led;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    mode_e            r_mode;
    logic [WIDTH-1:0] r_seq;     // source counter or checker expected value
    logic [WIDTH-1:0] r_tdata;
    logic             r_twrite;
    logic [31:0]      r_wc;
    logic [ERRW-1:0]  r_err;

    mode_e            w_mode;
    logic [WIDTH-1:0] w_word;
    logic             w_change;
    logic             w_active;
    logic             w_pop;
    logic             w_mismatch;

    assign w_mode     = mode_e'(mode[2*c +: 2]);
    assign w_word     = fpc_data[c*WIDTH +: WIDTH];
    // r_mode lags the input by one cycle, so a difference marks the cycle
    // in which the mode changed; that cycle neither pops nor pushes.
    assign w_change   = (w_mode != r_mode);
    assign w_active   = !reset && !fifo_reset[c] && !w_change;
    assign w_mismatch = (w_word != r_seq);

    always_comb begin
      w_pop = 1'b0;
      if (w_active) begin
        case (w_mode)
          MODE_LOOP: w_pop = fpc_ready[c] & tpc_ready[c];
          MODE_CHK:  w_pop = fpc_ready[c];
          default:   w_pop = 1'b0;
        endcase
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_mode   <= MODE_IDLE;
        r_seq    <= '0;
        r_tdata  <= '0;
        r_twrite <= 1'b0;
        r_wc     <= '0;
        r_err    <= '0;
      end else begin
        r_mode   <= w_mode;
        r_twrite <= 1'b0;
        if (fifo_reset[c] || w_change) begin
          r_seq <= '0;
          r_wc  <= '0;
        end else begin
          case (w_mode)
            MODE_LOOP: begin
              if (w_pop) begin
                r_twrite <= 1'b1;
                r_tdata  <= w_word;
                r_wc     <= r_wc + 32'd1;
              end
            end
            MODE_SRC: begin
              if (tpc_ready[c]) begin
                r_twrite <= 1'b1;
                r_tdata  <= r_seq;
                r_seq    <= r_seq + 1'b1;
                r_wc     <= r_wc + 32'd1;
              end
            end
            MODE_CHK: begin
              if (w_pop) begin
                r_wc  <= r_wc + 32'd1;
                // a mismatch resynchronises to the received word
                r_seq <= w_mismatch ? w_word + 1'b1 : r_seq + 1'b1;
              end
            end
            default: ;
          endcase
        end
        // err_clear takes priority over a coincident mismatch
        if (err_clear) begin
          r_err <= '0;
        end else if (w_pop && (w_mode == MODE_CHK) && w_mismatch && (r_err != '1)) begin
          r_err <= r_err + 1'b1;
        end
      end
    end

    assign fpc_read[c]                   = w_pop;
    assign tpc_write[c]                  = r_twrite;
    assign tpc_data[c*WIDTH +: WIDTH]    = r_tdata;
    assign word_count[c*32 +: 32]        = r_wc;
    assign err_count[c*ERRW +: ERRW]     = r_err;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_led <= 4'h5;
    end else if (fpc_read[0]) begin
      r_led <= fpc_data[3:0];
    end
  end

  assign led = r_led;

endmodule

// File: tb/tb_hififo_test_engine.sv
module tb_hififo_test_engine;
  localparam int CH = 2;
  localparam int W  = 8;
  localparam int E  = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [2*CH-1:0]   mode;
  logic [CH-1:0]     fifo_reset;
  logic              err_clear;
  logic [CH-1:0]     fpc_ready;
  logic [W*CH-1:0]   fpc_data;
  logic [CH-1:0]     fpc_read;
  logic [CH-1:0]     tpc_ready;
  logic [CH-1:0]     tpc_write;
  logic [W*CH-1:0]   tpc_data;
  logic [32*CH-1:0]  word_count;
  logic [E*CH-1:0]   err_count;
  logic [3:0]        led;

  int checks = 0;
  int errors = 0;

  // scoreboard: expected TPC pushes per channel
  logic [W-1:0] sb0[$];
  logic [W-1:0] sb1[$];
  logic [W-1:0] mon_exp;

  // channel-1 checker model
  logic [W-1:0] mexp;
  int           merr;
  int           mwc1;
  logic [W-1:0] d1;
  logic         rst0;

  hififo_test_engine #(.CHANNELS(CH), .WIDTH(W), .ERRW(E)) dut (
    .clock(clock), .reset(reset), .mode(mode), .fifo_reset(fifo_reset),
    .err_clear(err_clear), .fpc_ready(fpc_ready), .fpc_data(fpc_data),
    .fpc_read(fpc_read), .tpc_ready(tpc_ready), .tpc_write(tpc_write),
    .tpc_data(tpc_data), .word_count(word_count), .err_count(err_count), .led(led)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset) begin
      if (tpc_write[0]) begin
        checks++;
        if (sb0.size() == 0) begin
          errors++;
          $display("FAIL push0: unexpected push of %h", tpc_data[W-1:0]);
        end else begin
          mon_exp = sb0.pop_front();
          if (tpc_data[W-1:0] !== mon_exp) begin
            errors++;
            $display("FAIL push0: data %h expected %h", tpc_data[W-1:0], mon_exp);
          end
        end
      end
      if (tpc_write[1]) begin
        checks++;
        if (sb1.size() == 0) begin
          errors++;
          $display("FAIL push1: unexpected push of %h", tpc_data[2*W-1:W]);
        end else begin
          mon_exp = sb1.pop_front();
          if (tpc_data[2*W-1:W] !== mon_exp) begin
            errors++;
            $display("FAIL push1: data %h expected %h", tpc_data[2*W-1:W], mon_exp);
          end
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; mode = '0; fifo_reset = '0; err_clear = 1'b0;
    fpc_ready = '1; fpc_data = '0; tpc_ready = '1;
    repeat (3) @(negedge clock);
    checks++; if (tpc_write !== '0) begin errors++; $display("FAIL rst_twrite: %b expected 0", tpc_write); end
    checks++; if (tpc_data !== '0) begin errors++; $display("FAIL rst_tdata: %h expected 0", tpc_data); end
    checks++; if (word_count !== '0) begin errors++; $display("FAIL rst_wc: %h expected 0", word_count); end
    checks++; if (err_count !== '0) begin errors++; $display("FAIL rst_err: %h expected 0", err_count); end
    checks++; if (led !== 4'h5) begin errors++; $display("FAIL rst_led: %h expected 5", led); end
    checks++; if (fpc_read !== '0) begin errors++; $display("FAIL rst_fread: %b expected 0", fpc_read); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (tpc_write !== '0) begin errors++; $display("FAIL idle_twrite: %b expected 0", tpc_write); end
    checks++; if (fpc_read !== '0) begin errors++; $display("FAIL idle_fread: %b expected 0", fpc_read); end
    checks++; if (led !== 4'h5) begin errors++; $display("FAIL idle_led: %h expected 5", led); end
    fpc_ready = '0;
  endtask

  task automatic test_loopback();
    logic [W-1:0] w [3];
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
    mode[1:0] = 2'd1; tpc_ready = 2'b11;
    fpc_ready[0] = 1'b1; fpc_data[W-1:0] = w[0];
    #1;
    checks++; if (fpc_read[0] !== 1'b0) begin errors++; $display("FAIL lb_change_read: %b expected 0", fpc_read[0]); end
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      fpc_ready[0] = 1'b1; fpc_data[W-1:0] = w[i]; sb0.push_back(w[i]);
      #1;
      checks++; if (fpc_read[0] !== 1'b1) begin errors++; $display("FAIL lb_read%0d: %b expected 1", i, fpc_read[0]); end
      @(negedge clock);
      checks++; if (tpc_write[0] !== 1'b1) begin errors++; $display("FAIL lb_latency%0d: %b expected 1", i, tpc_write[0]); end
    end
    fpc_ready[0] = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (word_count[31:0] !== 32'd3) begin errors++; $display("FAIL lb_wc: %0d expected 3", word_count[31:0]); end
    checks++; if (led !== 4'h3) begin errors++; $display("FAIL lb_led: %h expected 3", led); end
    checks++; if (sb0.size() != 0) begin errors++; $display("FAIL lb_drain: %0d left expected 0", sb0.size()); end
  endtask

  task automatic test_source();
    logic [7:0]   pat;
    logic [W-1:0] m;
    pat = 8'b1100_1111; // bit i applies in cycle i
    m = '0;
    mode[3:2] = 2'd2; tpc_ready[1] = 1'b1;
    @(negedge clock);
    checks++; if (tpc_write[1] !== 1'b0) begin errors++; $display("FAIL src_change: %b expected 0", tpc_write[1]); end
    for (int i = 0; i < 8; i++) begin
      tpc_ready[1] = pat[i];
      if (pat[i]) begin sb1.push_back(m); m = m + 1'b1; end
      #1;
      checks++; if (fpc_read[1] !== 1'b0) begin errors++; $display("FAIL src_read%0d: %b expected 0", i, fpc_read[1]); end
      @(negedge clock);
      checks++; if (tpc_write[1] !== pat[i]) begin errors++; $display("FAIL src_write%0d: %b expected %b", i, tpc_write[1], pat[i]); end
    end
    tpc_ready[1] = 1'b0;
    @(negedge clock);
    checks++; if (word_count[63:32] !== 32'd6) begin errors++; $display("FAIL src_wc: %0d expected 6", word_count[63:32]); end
    checks++; if (sb1.size() != 0) begin errors++; $display("FAIL src_drain: %0d left expected 0", sb1.size()); end
  endtask

  task automatic test_checker();
    logic [W-1:0] w [6];
    w[0] = 8'd0; w[1] = 8'd1; w[2] = 8'd2; w[3] = 8'd7; w[4] = 8'd8; w[5] = 8'd5;
    mode[3:2] = 2'd3; tpc_ready[1] = 1'b1; fpc_ready[1] = 1'b1; fpc_data[2*W-1:W] = w[0];
    #1;
    checks++; if (fpc_read[1] !== 1'b0) begin errors++; $display("FAIL chk_change_read: %b expected 0", fpc_read[1]); end
    @(negedge clock);
    mexp = '0; merr = 0; mwc1 = 0;
    for (int i = 0; i < 6; i++) begin
      fpc_data[2*W-1:W] = w[i];
      mwc1++;
      if (w[i] != mexp) begin
        if (merr < 15) merr++;
        mexp = w[i] + 1'b1;
      end else begin
        mexp = mexp + 1'b1;
      end
      #1;
      checks++; if (fpc_read[1] !== 1'b1) begin errors++; $display("FAIL chk_read%0d: %b expected 1", i, fpc_read[1]); end
      @(negedge clock);
    end
    fpc_ready[1] = 1'b0;
    @(negedge clock);
    checks++; if (err_count[2*E-1:E] !== E'(merr)) begin errors++; $display("FAIL chk_err: %0d expected %0d", err_count[2*E-1:E], merr); end
    checks++; if (word_count[63:32] !== 32'(mwc1)) begin errors++; $display("FAIL chk_wc: %0d expected %0d", word_count[63:32], mwc1); end
  endtask

  task automatic test_wrap_saturate();
    logic [W-1:0] m;
    m = '0;
    mode[3:2] = 2'd2; tpc_ready[1] = 1'b0;
    @(negedge clock);
    tpc_ready[1] = 1'b1;
    for (int i = 0; i < 257; i++) begin
      sb1.push_back(m); m = m + 1'b1;
      @(negedge clock);
      if (i >= 254) begin
        checks++;
        if (tpc_data[2*W-1:W] !== W'(i)) begin errors++; $display("FAIL wrap%0d: %h expected %h", i, tpc_data[2*W-1:W], W'(i)); end
      end
    end
    tpc_ready[1] = 1'b0;
    @(negedge clock);
    checks++; if (word_count[63:32] !== 32'd257) begin errors++; $display("FAIL wrap_wc: %0d expected 257", word_count[63:32]); end
    checks++; if (sb1.size() != 0) begin errors++; $display("FAIL wrap_drain: %0d left expected 0", sb1.size()); end

    // checker fed a constant word: every pop after the first resync mismatches
    mode[3:2] = 2'd3;
    @(negedge clock);
    mexp = '0; mwc1 = 0;
    fpc_ready[1] = 1'b1; fpc_data[2*W-1:W] = 8'h80;
    for (int i = 0; i < 20; i++) begin
      mwc1++;
      if (fpc_data[2*W-1:W] != mexp) begin
        if (merr < 15) merr++;
        mexp = fpc_data[2*W-1:W] + 1'b1;
      end else begin
        mexp = mexp + 1'b1;
      end
      @(negedge clock);
      if (i == 12 || i == 19) begin
        checks++;
        if (err_count[2*E-1:E] !== E'(merr)) begin errors++; $display("FAIL sat%0d: %0d expected %0d", i, err_count[2*E-1:E], merr); end
      end
    end
    fpc_ready[1] = 1'b0;
    @(negedge clock);
    checks++; if (err_count[2*E-1:E] !== 4'hF) begin errors++; $display("FAIL sat_final: %h expected f", err_count[2*E-1:E]); end
  endtask

  task automatic test_fifo_reset_err_clear();
    tpc_ready = 2'b11;
    for (int k = 0; k < 8; k++) begin
      rst0 = (k == 3 || k == 4);
      fifo_reset[0] = rst0;
      fpc_ready[0] = 1'b1; fpc_data[W-1:0] = W'(64 + k);
      if (!rst0) sb0.push_back(fpc_data[W-1:0]);
      err_clear = (k == 5);
      d1 = (k == 5) ? (mexp ^ 8'h01) : mexp;
      fpc_ready[1] = 1'b1; fpc_data[2*W-1:W] = d1;
      mwc1++;
      if (err_clear) merr = 0;
      else if (d1 != mexp && merr < 15) merr++;
      mexp = (d1 == mexp) ? mexp + 1'b1 : d1 + 1'b1;
      #1;
      checks++; if (fpc_read[0] !== !rst0) begin errors++; $display("FAIL fr_read%0d: %b expected %b", k, fpc_read[0], !rst0); end
      checks++; if (fpc_read[1] !== 1'b1) begin errors++; $display("FAIL fr_read1_%0d: %b expected 1", k, fpc_read[1]); end
      @(negedge clock);
      checks++; if (tpc_write[0] !== !rst0) begin errors++; $display("FAIL fr_write%0d: %b expected %b", k, tpc_write[0], !rst0); end
      if (k == 4) begin
        checks++; if (word_count[31:0] !== 32'd0) begin errors++; $display("FAIL fr_wc_clear: %0d expected 0", word_count[31:0]); end
      end
    end
    fifo_reset = '0; err_clear = 1'b0; fpc_ready = '0;
    @(negedge clock);
    checks++; if (err_count[2*E-1:E] !== E'(merr)) begin errors++; $display("FAIL fr_err: %0d expected %0d", err_count[2*E-1:E], merr); end
    checks++; if (word_count[63:32] !== 32'(mwc1)) begin errors++; $display("FAIL fr_wc1: %0d expected %0d", word_count[63:32], mwc1); end
    checks++; if (word_count[31:0] !== 32'd3) begin errors++; $display("FAIL fr_wc0: %0d expected 3", word_count[31:0]); end
    checks++; if (sb0.size() != 0) begin errors++; $display("FAIL fr_drain: %0d left expected 0", sb0.size()); end
    checks++; if (led !== 4'h7) begin errors++; $display("FAIL fr_led: %h expected 7", led); end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    fpc_ready[0] = 1'b1;
    #2 reset = 1'b1;
    #1;
    checks++; if (word_count !== '0) begin errors++; $display("FAIL async_wc: %h expected 0", word_count); end
    checks++; if (led !== 4'h5) begin errors++; $display("FAIL async_led: %h expected 5", led); end
    checks++; if (fpc_read !== '0) begin errors++; $display("FAIL async_read: %b expected 0", fpc_read); end
    checks++; if (tpc_write !== '0) begin errors++; $display("FAIL async_write: %b expected 0", tpc_write); end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_source();
    test_checker();
    test_wrap_saturate();
    test_fifo_reset_err_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
